fifo_uart_drain: RTL

- Downstream consumer of the 8-bit fifo: pops one byte whenever the fifo is non-empty and the serializer is idle, then shifts it out as an asynchronous serial frame on a single pin.
- Frame format: start bit, 8 data bits LSB first, optional even parity bit, 1 or 2 stop bits.
- Sits between the fifo's output byte and empty flag and the chip's serial output pin. Also exposes busy status and a frame counter.

---
 rtl/fifo_uart_pkg.sv | 18 +
 rtl/fifo_uart_drain_baud_tick_gen.sv | 29 ++
 rtl/fifo_uart_drain.sv | 122 ++++++++++++
 3 files changed

// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the fifo-to-UART drain block.
package fifo_uart_pkg;

  localparam int   STATE_W   = 3;
  localparam int   DATA_BITS = 8;
  localparam logic TX_IDLE   = 1'b1;

  typedef enum logic [STATE_W-1:0] {
    IDLE,
    REQ,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

endpackage

// File: rtl/fifo_uart_drain_baud_tick_gen.sv
// Bit-period counter: emits a one-cycle tick on the last clk of every serial bit.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int                CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST) && !clear;

endmodule

// File: rtl/fifo_uart_drain.sv
// Pops bytes from an 8-bit fifo and serialises them as async frames on tx.
module fifo_uart_drain
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        fifo_empty,
  output logic        fifo_rd_req,
  input  logic [7:0]  fifo_data,
  output logic        tx,
  output logic        busy,
  output logic [15:0] frames_sent
);

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  state_t     state;
  logic [7:0] shift;
  logic       parity;
  logic [2:0] bit_cnt;
  logic       stop_cnt;
  logic       tick;
  logic       baud_clear;

  // The bit timer only runs once the start bit begins, so START always gets a full period.
  assign baud_clear = (state == IDLE) || (state == REQ) || (state == LOAD);

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (baud_clear),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tx          <= TX_IDLE;
      fifo_rd_req <= 1'b0;
      busy        <= 1'b0;
      frames_sent <= '0;
      shift       <= '0;
      parity      <= 1'b0;
      bit_cnt     <= '0;
      stop_cnt    <= 1'b0;
    end else begin
      fifo_rd_req <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && !fifo_empty) begin
            fifo_rd_req <= 1'b1;
            busy        <= 1'b1;
            state       <= REQ;
          end
        end
        REQ: state <= LOAD;
        LOAD: begin
          shift    <= fifo_data;
          parity   <= ^fifo_data;
          bit_cnt  <= '0;
          stop_cnt <= 1'b0;
          tx       <= 1'b0;
          state    <= START;
        end
        START: begin
          if (tick) begin
            tx    <= shift[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt == LAST_BIT) begin
              if (PARITY_EN != 0) begin
                tx    <= parity;
                state <= PARITY;
              end else begin
                tx    <= TX_IDLE;
                state <= STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
            end
          end
        end
        PARITY: begin
          if (tick) begin
            tx    <= TX_IDLE;
            state <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            if (stop_cnt == LAST_STOP) begin
              frames_sent <= frames_sent + 16'd1;
              busy        <= 1'b0;
              state       <= IDLE;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: begin
          tx    <= TX_IDLE;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
